// File: rtl/ahb_apb_pkg.sv
// Shared encodings for the parametrised AHB-to-APB bridge.
// Holds the AHB transfer and response codes and the bridge FSM states.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } bridge_st_e;

endpackage

// File: rtl/apb_addr_decoder.sv
// Address decoder for the APB slave window.
// Slave i occupies [SLV_BASE + i<<SLV_SPAN_LOG2, SLV_BASE + (i+1)<<SLV_SPAN_LOG2).
// Ports:
//   addr : address to decode
//   hit  : address falls inside one of the NUM_SLAVES regions
//   idx  : binary slave index (only meaningful when hit)
//   sel  : one-hot slave select, all zero on a miss
module apb_addr_decoder #(
  parameter int                ADDR_W        = 32,
  parameter int                NUM_SLAVES    = 3,
  parameter logic [ADDR_W-1:0] SLV_BASE      = 32'h8000_0000,
  parameter int                SLV_SPAN_LOG2 = 26,
  localparam int               IDX_W         = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx,
  output logic [NUM_SLAVES-1:0] sel
);

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] slot;

  // Offset from the base wraps for addresses below it, so the lower bound
  // is checked separately rather than trusting the slot number alone.
  assign off  = addr - SLV_BASE;
  assign slot = off >> SLV_SPAN_LOG2;
  assign hit  = (addr >= SLV_BASE) && (slot < ADDR_W'(NUM_SLAVES));
  assign idx  = slot[IDX_W-1:0];
  assign sel  = hit ? (NUM_SLAVES'(1) << idx) : '0;

endmodule

// File: rtl/ahb2apb_bridge_mc.sv
// Parametrised AHB-to-APB bridge.
// Captures one AHB transfer at a time, runs it as an APB SETUP/ACCESS pair on
// the decoded slave, honours pready wait states and turns pslverr, decode
// misses and a pready timeout into a two-cycle AHB ERROR response.
// Ports:
//   hclk, hreset                    : clock, synchronous active-high reset
//   hwrite/hreadyin/htrans/haddr    : AHB address phase
//   hwdata                          : AHB write data (sampled in WDATA)
//   hrdata/hreadyout/hresp          : AHB response
//   paddr/pwdata/pwrite/penable/psel: APB request, psel one-hot per slave
//   prdata/pready/pslverr           : per-slave APB response, packed by slave
module ahb2apb_bridge_mc
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter int                NUM_SLAVES    = 3,
  parameter logic [ADDR_W-1:0] SLV_BASE      = 32'h8000_0000,
  parameter int                SLV_SPAN_LOG2 = 26,
  parameter int                TIMEOUT       = 16
) (
  input  logic                         hclk,
  input  logic                         hreset,
  input  logic                         hwrite,
  input  logic                         hreadyin,
  input  logic [1:0]                   htrans,
  input  logic [ADDR_W-1:0]            haddr,
  input  logic [DATA_W-1:0]            hwdata,
  output logic [DATA_W-1:0]            hrdata,
  output logic                         hreadyout,
  output logic [1:0]                   hresp,
  output logic [ADDR_W-1:0]            paddr,
  output logic [DATA_W-1:0]            pwdata,
  output logic                         pwrite,
  output logic                         penable,
  output logic [NUM_SLAVES-1:0]        psel,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES-1:0]        pslverr
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  bridge_st_e              state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [IDX_W-1:0]        idx_q, dec_idx;
  logic [NUM_SLAVES-1:0]   sel_q, dec_sel;
  logic                    dec_hit;
  logic                    valid, capture, xfer_ok;
  logic                    sel_ready, sel_err;
  logic [DATA_W-1:0]       sel_rdata;

  apb_addr_decoder #(
    .ADDR_W       (ADDR_W),
    .NUM_SLAVES   (NUM_SLAVES),
    .SLV_BASE     (SLV_BASE),
    .SLV_SPAN_LOG2(SLV_SPAN_LOG2)
  ) u_dec (
    .addr(haddr),
    .hit (dec_hit),
    .idx (dec_idx),
    .sel (dec_sel)
  );

  assign valid     = hreadyin && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  // Only the selected slave's response is looked at.
  assign sel_ready = pready[idx_q];
  assign sel_err   = pslverr[idx_q];
  assign sel_rdata = prdata[idx_q*DATA_W +: DATA_W];

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    capture   = 1'b0;
    xfer_ok   = 1'b0;
    hreadyout = 1'b0;
    hresp     = HRESP_OKAY;
    psel      = '0;
    penable   = 1'b0;
    case (state)
      // ERR2 is the completing cycle of an error, so it accepts the next
      // address exactly like IDLE does.
      ST_IDLE, ST_ERR2: begin
        hreadyout = 1'b1;
        if (state == ST_ERR2) hresp = HRESP_ERROR;
        state_n = ST_IDLE;
        if (valid) begin
          capture = 1'b1;
          if (!dec_hit)    state_n = ST_ERR1;
          else if (hwrite) state_n = ST_WDATA;
          else             state_n = ST_SETUP;
        end
      end
      ST_WDATA: state_n = ST_SETUP;
      ST_SETUP: begin
        psel    = sel_q;
        cnt_n   = '0;
        state_n = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel    = sel_q;
        penable = 1'b1;
        if (sel_ready) begin
          cnt_n   = '0;
          xfer_ok = !sel_err;
          state_n = sel_err ? ST_ERR1 : ST_IDLE;
        end else if ((TIMEOUT > 0) && (cnt == CNT_W'(TIMEOUT - 1))) begin
          // This cycle is the TIMEOUT-th wait cycle: give up.
          cnt_n   = '0;
          state_n = ST_ERR1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_ERR1: begin
        hresp   = HRESP_ERROR;
        state_n = ST_ERR2;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      paddr  <= '0;
      pwdata <= '0;
      pwrite <= 1'b0;
      hrdata <= '0;
      idx_q  <= '0;
      sel_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (capture) begin
        paddr  <= haddr;
        pwrite <= hwrite;
        idx_q  <= dec_idx;
        sel_q  <= dec_sel;
      end
      if (state == ST_WDATA) pwdata <= hwdata;
      if (xfer_ok && !pwrite) hrdata <= sel_rdata;
    end
  end

endmodule

// File: tb/tb_ahb2apb_bridge_mc.sv
// Directed bench for ahb2apb_bridge_mc: a cycle table for single transfers,
// errors, decode edges and reset, then hand sequences for a wrap burst and
// the pready timeout.
module tb_ahb2apb_bridge_mc;

  localparam logic [1:0] T_I = 2'b00, T_B = 2'b01, T_N = 2'b10, T_S = 2'b11;
  localparam logic [31:0] A1  = 32'h8000_0010, W1 = 32'hA5A5_1234;
  localparam logic [31:0] A2  = 32'h8400_0004, RD1 = 32'hDEAD_BEEF;
  localparam logic [31:0] A3  = 32'h8800_0000, RD2 = 32'h2222_2222;
  localparam logic [31:0] A2L = 32'h8BFF_FFFC;

  logic        hclk = 1'b0, hreset = 1'b1, hwrite = 1'b0, hreadyin = 1'b1;
  logic [1:0]  htrans = 2'b00;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [31:0] hrdata, paddr, pwdata;
  logic        hreadyout, pwrite, penable;
  logic [1:0]  hresp;
  logic [2:0]  psel;
  logic [95:0] prdata;
  logic [2:0]  pready = 3'b111, pslverr = 3'b000;

  int n_vec = 0, n_err = 0;

  always #5 hclk = ~hclk;

  assign prdata = {RD2, RD1, 32'h1111_0000};

  ahb2apb_bridge_mc dut (
    .hclk(hclk), .hreset(hreset), .hwrite(hwrite), .hreadyin(hreadyin),
    .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata),
    .hreadyout(hreadyout), .hresp(hresp), .paddr(paddr), .pwdata(pwdata),
    .pwrite(pwrite), .penable(penable), .psel(psel), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    logic rst, rin; logic [1:0] trans; logic wr; logic [31:0] addr, wdata;
    logic [2:0] rdy, err;
    logic e_rdy; logic [1:0] e_resp; logic [2:0] e_psel; logic e_pen; logic chk;
    logic [31:0] e_paddr, e_pwdata; logic e_pwrite; logic [31:0] e_hrdata;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] BA[4] = '{32'h8000_0038, 32'h8000_003C, 32'h8000_0030, 32'h8000_0034};
  logic [31:0] BD[4] = '{32'h0B0B_0000, 32'h0B0B_0001, 32'h0B0B_0002, 32'h0B0B_0003};

  function automatic vec_t mk(
    input logic rst, rin, input logic [1:0] trans, input logic wr,
    input logic [31:0] addr, wdata, input logic [2:0] rdy, err,
    input logic e_rdy, input logic [1:0] e_resp, input logic [2:0] e_psel,
    input logic e_pen, chk, input logic [31:0] e_paddr, e_pwdata,
    input logic e_pwrite, input logic [31:0] e_hrdata);
    vec_t v;
    v.rst = rst; v.rin = rin; v.trans = trans; v.wr = wr; v.addr = addr;
    v.wdata = wdata; v.rdy = rdy; v.err = err; v.e_rdy = e_rdy;
    v.e_resp = e_resp; v.e_psel = e_psel; v.e_pen = e_pen; v.chk = chk;
    v.e_paddr = e_paddr; v.e_pwdata = e_pwdata; v.e_pwrite = e_pwrite;
    v.e_hrdata = e_hrdata;
    return v;
  endfunction

  // Expected-only record for the hand sequences.
  function automatic vec_t ex(
    input logic e_rdy, input logic [1:0] e_resp, input logic [2:0] e_psel,
    input logic e_pen, chk, input logic [31:0] e_paddr, e_pwdata,
    input logic e_pwrite, input logic [31:0] e_hrdata);
    return mk(0, 1, T_I, 0, 0, 0, 0, 0, e_rdy, e_resp, e_psel, e_pen, chk,
              e_paddr, e_pwdata, e_pwrite, e_hrdata);
  endfunction

  task automatic drive(input vec_t v);
    hreset = v.rst; hreadyin = v.rin; htrans = v.trans; hwrite = v.wr;
    haddr = v.addr; hwdata = v.wdata; pready = v.rdy; pslverr = v.err;
  endtask

  task automatic check(input string name, input vec_t v);
    logic bad;
    bad = (hreadyout !== v.e_rdy) || (hresp !== v.e_resp) ||
          (psel !== v.e_psel) || (penable !== v.e_pen);
    if (v.chk)
      bad = bad || (paddr !== v.e_paddr) || (pwdata !== v.e_pwdata) ||
            (pwrite !== v.e_pwrite) || (hrdata !== v.e_hrdata);
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL %s: got rdy=%0b resp=%0d psel=%b pen=%0b paddr=%h pwdata=%h pwrite=%0b hrdata=%h; want rdy=%0b resp=%0d psel=%b pen=%0b paddr=%h pwdata=%h pwrite=%0b hrdata=%h (data %s)",
               name, hreadyout, hresp, psel, penable, paddr, pwdata, pwrite, hrdata,
               v.e_rdy, v.e_resp, v.e_psel, v.e_pen, v.e_paddr, v.e_pwdata,
               v.e_pwrite, v.e_hrdata, v.chk ? "checked" : "ignored");
    end
  endtask

  initial begin
    // rst rin trans wr addr wdata rdy err | rdy resp psel pen chk paddr pwdata pwrite hrdata
    vecs.push_back(mk(1,1,T_I,0,0,0,3'b111,0,        1,0,3'b000,0, 1,0,0,0,0));
    // single write, zero wait states
    vecs.push_back(mk(0,1,T_N,1,A1,0,3'b111,0,       0,0,3'b000,0, 1,A1,0,1,0));
    vecs.push_back(mk(0,1,T_I,0,0,W1,3'b111,0,       0,0,3'b001,0, 1,A1,W1,1,0));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b111,0,        0,0,3'b001,1, 1,A1,W1,1,0));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b111,0,        1,0,3'b000,0, 1,A1,W1,1,0));
    // read slave1, two wait cycles, other slaves' err lines ignored
    vecs.push_back(mk(0,1,T_N,0,A2,0,3'b111,0,       0,0,3'b010,0, 1,A2,W1,0,0));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b000,0,        0,0,3'b010,1, 1,A2,W1,0,0));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b000,0,        0,0,3'b010,1, 1,A2,W1,0,0));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b000,0,        0,0,3'b010,1, 1,A2,W1,0,0));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b010,3'b101,   1,0,3'b000,0, 1,A2,W1,0,RD1));
    // read slave2 with pslverr
    vecs.push_back(mk(0,1,T_N,0,A3,0,3'b111,0,       0,0,3'b100,0, 1,A3,W1,0,RD1));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b000,0,        0,0,3'b100,1, 1,A3,W1,0,RD1));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b100,3'b100,   0,1,3'b000,0, 1,A3,W1,0,RD1));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b111,0,        1,1,3'b000,0, 1,A3,W1,0,RD1));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b111,0,        1,0,3'b000,0, 1,A3,W1,0,RD1));
    // decode miss above the window
    vecs.push_back(mk(0,1,T_N,0,32'h9000_0000,0,3'b111,0, 0,1,3'b000,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b111,0,        1,1,3'b000,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b111,0,        1,0,3'b000,0, 0,0,0,0,0));
    // BUSY and hreadyin=0 are not transfers
    vecs.push_back(mk(0,1,T_B,1,32'h8000_0000,0,3'b111,0, 1,0,3'b000,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,T_N,0,32'h8000_0000,0,3'b111,0, 1,0,3'b000,0, 0,0,0,0,0));
    // just below base misses; transfer presented in ERR2 is taken
    vecs.push_back(mk(0,1,T_N,0,32'h7FFF_FFFC,0,3'b111,0, 0,1,3'b000,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b111,0,        1,1,3'b000,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,T_N,0,A2L,0,3'b111,0,      0,0,3'b100,0, 1,A2L,W1,0,RD1));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b111,0,        0,0,3'b100,1, 1,A2L,W1,0,RD1));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b111,0,        1,0,3'b000,0, 1,A2L,W1,0,RD2));
    // first byte past the last region misses (write goes straight to error)
    vecs.push_back(mk(0,1,T_N,1,32'h8C00_0000,0,3'b111,0, 0,1,3'b000,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b111,0,        1,1,3'b000,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b111,0,        1,0,3'b000,0, 0,0,0,0,0));
    // reset during ACCESS wins over a presented transfer
    vecs.push_back(mk(0,1,T_N,0,32'h8000_0000,0,3'b000,0, 0,0,3'b001,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b000,0,        0,0,3'b001,1, 0,0,0,0,0));
    vecs.push_back(mk(1,1,T_N,0,32'h8000_0000,0,3'b000,0, 1,0,3'b000,0, 1,0,0,0,0));
    vecs.push_back(mk(0,1,T_I,0,0,0,3'b111,0,        1,0,3'b000,0, 1,0,0,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge hclk);
      @(negedge hclk);
      check($sformatf("vec%0d", i), vecs[i]);
    end

    // 4-beat wrap write burst; next beat is captured in the completing cycle
    hreset = 0; hreadyin = 1; pready = 3'b111; pslverr = 3'b000;
    haddr = BA[0]; htrans = T_N; hwrite = 1;
    @(posedge hclk);
    for (int i = 0; i < 4; i++) begin
      #1;
      hwdata = BD[i];
      if (i < 3) begin haddr = BA[i+1]; htrans = T_S; end
      else begin haddr = '0; htrans = T_I; hwrite = 0; end
      @(negedge hclk);
      check($sformatf("burst%0d_wdata", i), ex(0,0,3'b000,0, 1,BA[i],(i == 0) ? 32'h0 : BD[i-1],1,0));
      @(posedge hclk); @(negedge hclk);
      check($sformatf("burst%0d_setup", i), ex(0,0,3'b001,0, 1,BA[i],BD[i],1,0));
      @(posedge hclk); @(negedge hclk);
      check($sformatf("burst%0d_access", i), ex(0,0,3'b001,1, 1,BA[i],BD[i],1,0));
      @(posedge hclk); @(negedge hclk);
      check($sformatf("burst%0d_done", i), ex(1,0,3'b000,0, 1,BA[i],BD[i],1,0));
      @(posedge hclk);
    end

    // pready stuck low: error after 16 ACCESS cycles
    #1;
    haddr = 32'h8400_0000; htrans = T_N; hwrite = 0; pready = 3'b000;
    @(posedge hclk);
    #1 htrans = T_I;
    @(negedge hclk);
    check("tmo_setup", ex(0,0,3'b010,0, 1,32'h8400_0000,BD[3],0,0));
    @(posedge hclk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge hclk);
      check($sformatf("tmo_access%0d", k), ex(0,0,3'b010,1, 1,32'h8400_0000,BD[3],0,0));
      @(posedge hclk);
    end
    @(negedge hclk);
    check("tmo_err1", ex(0,1,3'b000,0, 1,32'h8400_0000,BD[3],0,0));
    @(posedge hclk); @(negedge hclk);
    check("tmo_err2", ex(1,1,3'b000,0, 1,32'h8400_0000,BD[3],0,0));
    @(posedge hclk); @(negedge hclk);
    check("tmo_idle", ex(1,0,3'b000,0, 1,32'h8400_0000,BD[3],0,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
